// File: rtl/mmio_arb_pkg.sv
// Shared types and widths for the MMIO bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mmio_arb_pkg;

   localparam int MMIO_ADDR_W = 21;
   localparam int MMIO_DATA_W = 32;

   // Arbiter transaction sequencer: pick a winner, run one bus cycle, report completion.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

endpackage : mmio_arb_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request above last_grant, wrapping.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last_grant,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   int   cand;
   logic found;

   // Scan upward from last_grant+1 so the most recent winner gets lowest priority.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = 0;
      for (int off = 1; off <= N; off++) begin
         cand = (int'(last_grant) + off) % N;
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = IDX_W'(cand);
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/mmio_arbiter.sv
// Round-robin share of one MMIO bus among NUM_MASTERS requesters, one registered bus cycle per grant.
// Latency: request sampled at edge k, bus cycle k+1, m_ready/m_read_data valid in cycle k+2.
// Backpressure: requesters hold m_req until their m_ready pulse; one transaction every 3 cycles.
module mmio_arbiter
   import mmio_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = MMIO_ADDR_W,
   parameter int DATA_W      = MMIO_DATA_W
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_MASTERS-1:0]        m_req,
   input  logic [NUM_MASTERS-1:0]        m_write,
   input  logic [NUM_MASTERS-1:0]        m_read,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_write_data,
   output logic [NUM_MASTERS-1:0]        m_ready,
   output logic [DATA_W-1:0]             m_read_data,
   output logic                          mmio_cs,
   output logic                          mmio_write,
   output logic                          mmio_read,
   output logic [ADDR_W-1:0]             mmio_addr,
   output logic [DATA_W-1:0]             mmio_write_data,
   input  logic [DATA_W-1:0]             mmio_read_data
);

   localparam int IDX_W = $clog2(NUM_MASTERS);

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       last_grant_q, last_grant_d;
   logic                   cs_q, cs_d;
   logic                   write_q, write_d;
   logic                   read_q, read_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   logic [NUM_MASTERS-1:0] ready_q, ready_d;
   logic [DATA_W-1:0]      rdata_q, rdata_d;

   logic [NUM_MASTERS-1:0] arb_gnt;
   logic [IDX_W-1:0]       arb_idx;

   rr_arbiter #(
      .N     (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req        (m_req),
      .last_grant (last_grant_q),
      .gnt        (arb_gnt),
      .gnt_idx    (arb_idx)
   );

   // State and output registers; reset drops the bus immediately so no write is half-driven.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         last_grant_q <= IDX_W'(NUM_MASTERS - 1);
         cs_q         <= 1'b0;
         write_q      <= 1'b0;
         read_q       <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         ready_q      <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cs_q         <= cs_d;
         write_q      <= write_d;
         read_q       <= read_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         ready_q      <= ready_d;
         rdata_q      <= rdata_d;
      end
   end

   // Next state: any request starts a transaction; ACCESS and DONE each last one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|m_req) state_d = ACCESS;
         ACCESS:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus and completion values for the next cycle; bus outputs are zero except during ACCESS.
   always_comb begin
      last_grant_d = last_grant_q;
      cs_d         = 1'b0;
      write_d      = 1'b0;
      read_d       = 1'b0;
      addr_d       = '0;
      wdata_d      = '0;
      ready_d      = '0;
      rdata_d      = rdata_q;
      case (state_q)
         IDLE: begin
            if (|m_req) begin
               // Latch the winner's request now; later requester changes are ignored.
               // A simultaneous write and read is performed as a write only.
               last_grant_d = arb_idx;
               write_d      = |(m_write & arb_gnt);
               read_d       = |(m_read & arb_gnt) & ~write_d;
               cs_d         = write_d | read_d;
               addr_d       = m_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
               wdata_d      = m_write_data[int'(arb_idx)*DATA_W +: DATA_W];
            end
         end
         ACCESS: begin
            // last_grant_q holds the current winner for the rest of the transaction.
            if (read_q) rdata_d = mmio_read_data;
            ready_d[last_grant_q] = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign m_ready         = ready_q;
   assign m_read_data     = rdata_q;
   assign mmio_cs         = cs_q;
   assign mmio_write      = write_q;
   assign mmio_read       = read_q;
   assign mmio_addr       = addr_q;
   assign mmio_write_data = wdata_q;

endmodule : mmio_arbiter
